// File: rtl/pipe_stage_pkg.sv
// Shared constants for the generic inter-stage pipeline register.
package pipe_stage_pkg;

  // Flush behaviour for the datapath bundle
  localparam bit FLUSH_KEEP_DATA = 1'b0;
  localparam bit FLUSH_ZERO_DATA = 1'b1;

  // Occupancy encoding
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Default bundle widths for each core stage boundary
  localparam int IF_ID_CTRL_W   = 8;
  localparam int IF_ID_DATA_W   = 64;
  localparam int ID_EX_CTRL_W   = 32;
  localparam int ID_EX_DATA_W   = 128;
  localparam int EX_MEM_CTRL_W  = 16;
  localparam int EX_MEM_DATA_W  = 96;
  localparam int MEM_WB_CTRL_W  = 8;
  localparam int MEM_WB_DATA_W  = 64;

  // Next occupancy given one optional arrival and one optional departure
  function automatic logic [1:0] occ_step(input logic [1:0] occ,
                                          input logic       inc,
                                          input logic       dec);
    logic [1:0] nxt;
    case ({inc, dec})
      2'b10:   nxt = occ + 2'd1;
      2'b01:   nxt = occ - 2'd1;
      default: nxt = occ;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// One pipeline entry: valid bit, control bundle and datapath bundle.
// clear beats load beats drop; drop empties the entry and zeroes control
// so a non-valid entry never shows live control bits.
module pipe_stage_slot
  import pipe_stage_pkg::*;
#(
  parameter int CTRL_W     = 32,
  parameter int DATA_W     = 128,
  parameter bit FLUSH_DATA = FLUSH_ZERO_DATA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] data_r;

  // Entry state: reset, flush-clear, load a new beat, or drop the taken beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
    end else if (clear) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
      if (FLUSH_DATA == FLUSH_ZERO_DATA) begin
        data_r <= {DATA_W{1'b0}};
      end else begin
        data_r <= data_r;
      end
    end else if (load) begin
      valid_r <= 1'b1;
      ctrl_r  <= ld_ctrl;
      data_r  <= ld_data;
    end else if (drop) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
    end
  end

  assign valid = valid_r;
  assign ctrl  = ctrl_r;
  assign data  = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// synchronous flush, sticky flags and an optional skid entry.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int CTRL_W     = 32,
  parameter int DATA_W     = 128,
  parameter int STICKY_W   = 1,
  parameter bit SKID_EN    = 1'b1,
  parameter bit FLUSH_DATA = FLUSH_ZERO_DATA
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CTRL_W-1:0]   in_ctrl,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [STICKY_W-1:0] in_sticky,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CTRL_W-1:0]   out_ctrl,
  output logic [DATA_W-1:0]   out_data,
  output logic [STICKY_W-1:0] out_sticky,
  output logic [1:0]          occupancy
);

  logic                accept_s;
  logic                take_s;
  logic                in_ready_s;
  logic                main_valid_s;
  logic                main_load_s;
  logic                main_drop_s;
  logic [CTRL_W-1:0]   main_ld_ctrl_s;
  logic [DATA_W-1:0]   main_ld_data_s;
  logic [STICKY_W-1:0] main_ld_sticky_s;
  logic                skid_valid_s;
  logic [CTRL_W-1:0]   skid_ctrl_s;
  logic [DATA_W-1:0]   skid_data_s;
  logic [STICKY_W-1:0] skid_sticky_s;
  logic [STICKY_W-1:0] sticky_r;
  logic [1:0]          occ_r;

  assign accept_s = in_valid && in_ready_s;
  assign take_s   = main_valid_s && out_ready;

  generate
    if (SKID_EN) begin : g_skid
      logic                         skid_load_s;
      logic                         skid_drop_s;
      logic                         in_ready_r;
      logic [DATA_W+STICKY_W-1:0]   skid_payload_s;

      // Skid fills when a beat arrives while main stays busy; drains into main
      always_comb begin
        skid_load_s = 1'b0;
        skid_drop_s = 1'b0;
        if (flush) begin
          skid_load_s = 1'b0;
          skid_drop_s = 1'b0;
        end else begin
          skid_load_s = accept_s && main_valid_s && !take_s;
          skid_drop_s = skid_valid_s && (!main_valid_s || take_s);
        end
      end

      pipe_stage_slot #(
        .CTRL_W     (CTRL_W),
        .DATA_W     (DATA_W + STICKY_W),
        .FLUSH_DATA (FLUSH_ZERO_DATA)
      ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .load    (skid_load_s),
        .drop    (skid_drop_s),
        .ld_ctrl (in_ctrl),
        .ld_data ({in_sticky, in_data}),
        .valid   (skid_valid_s),
        .ctrl    (skid_ctrl_s),
        .data    (skid_payload_s)
      );

      assign skid_data_s   = skid_payload_s[DATA_W-1:0];
      assign skid_sticky_s = skid_payload_s[DATA_W+STICKY_W-1:DATA_W];

      // Registered ready: mirrors the next-cycle emptiness of the skid entry
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          in_ready_r <= 1'b1;
        end else if (flush) begin
          in_ready_r <= 1'b1;
        end else if (skid_load_s) begin
          in_ready_r <= 1'b0;
        end else if (skid_drop_s) begin
          in_ready_r <= 1'b1;
        end else begin
          in_ready_r <= !skid_valid_s;
        end
      end

      assign in_ready_s = in_ready_r;
    end else begin : g_noskid
      assign skid_valid_s  = 1'b0;
      assign skid_ctrl_s   = {CTRL_W{1'b0}};
      assign skid_data_s   = {DATA_W{1'b0}};
      assign skid_sticky_s = {STICKY_W{1'b0}};
      assign in_ready_s    = !main_valid_s || out_ready;
    end
  endgenerate

  // Main entry steering: refill from skid first so beat order is preserved
  always_comb begin
    main_load_s      = 1'b0;
    main_drop_s      = 1'b0;
    main_ld_ctrl_s   = in_ctrl;
    main_ld_data_s   = in_data;
    main_ld_sticky_s = in_sticky;
    if (flush) begin
      main_load_s = 1'b0;
      main_drop_s = 1'b0;
    end else begin
      main_load_s = (!main_valid_s || take_s) && (skid_valid_s || accept_s);
      main_drop_s = take_s && !(skid_valid_s || accept_s);
    end
    if (skid_valid_s) begin
      main_ld_ctrl_s   = skid_ctrl_s;
      main_ld_data_s   = skid_data_s;
      main_ld_sticky_s = skid_sticky_s;
    end else begin
      main_ld_ctrl_s   = in_ctrl;
      main_ld_data_s   = in_data;
      main_ld_sticky_s = in_sticky;
    end
  end

  pipe_stage_slot #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .FLUSH_DATA (FLUSH_DATA)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .load    (main_load_s),
    .drop    (main_drop_s),
    .ld_ctrl (main_ld_ctrl_s),
    .ld_data (main_ld_data_s),
    .valid   (main_valid_s),
    .ctrl    (out_ctrl),
    .data    (out_data)
  );

  // Sticky flags follow each beat into main; flush leaves them alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_r <= {STICKY_W{1'b0}};
    end else if (main_load_s) begin
      sticky_r <= main_ld_sticky_s;
    end
  end

  // Live-beat counter: +1 per accept, -1 per take, emptied by flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_r <= OCC_EMPTY;
    end else if (flush) begin
      occ_r <= OCC_EMPTY;
    end else begin
      occ_r <= occ_step(occ_r, accept_s, take_s);
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = main_valid_s;
  assign out_sticky = sticky_r;
  assign occupancy  = SKID_EN ? occ_r : {1'b0, occ_r[0]};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one skid/zero-data instance (a_*)
// and one no-skid/keep-data instance (b_*).
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;

  logic          a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [CW-1:0] a_in_ctrl = '0;
  logic [DW-1:0] a_in_data = '0;
  logic [0:0]    a_in_sticky = '0;
  logic          a_in_ready, a_out_valid;
  logic [CW-1:0] a_out_ctrl;
  logic [DW-1:0] a_out_data;
  logic [0:0]    a_out_sticky;
  logic [1:0]    a_occ;

  logic          b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [CW-1:0] b_in_ctrl = '0;
  logic [DW-1:0] b_in_data = '0;
  logic [0:0]    b_in_sticky = '0;
  logic          b_in_ready, b_out_valid;
  logic [CW-1:0] b_out_ctrl;
  logic [DW-1:0] b_out_data;
  logic [0:0]    b_out_sticky;
  logic [1:0]    b_occ;

  int checks = 0;
  int errors = 0;
  logic [24:0] qa[$];
  logic [24:0] qb[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STICKY_W(1), .SKID_EN(1'b1), .FLUSH_DATA(1'b1)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_ctrl(a_in_ctrl), .in_data(a_in_data), .in_sticky(a_in_sticky), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data), .out_sticky(a_out_sticky),
    .occupancy(a_occ));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STICKY_W(1), .SKID_EN(1'b0), .FLUSH_DATA(1'b0)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_ctrl(b_in_ctrl), .in_data(b_in_data), .in_sticky(b_in_sticky), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data), .out_sticky(b_out_sticky),
    .occupancy(b_occ));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] ctrl_of(input logic [DW-1:0] d);
    return d[7:0] ^ 8'h3C;
  endfunction

  // One cycle of stimulus on instance A; records beats that will be accepted
  task automatic drive_a(input logic v, input logic [DW-1:0] d, input logic s,
                         input logic ordy, input logic fl);
    a_in_valid = v; a_in_data = d; a_in_ctrl = ctrl_of(d); a_in_sticky = s;
    a_out_ready = ordy; a_flush = fl;
    @(negedge clk);
    if (v && a_in_ready && !fl) qa.push_back({s, ctrl_of(d), d});
    @(posedge clk); #1;
  endtask

  task automatic drive_b(input logic v, input logic [DW-1:0] d, input logic s,
                         input logic ordy, input logic fl);
    b_in_valid = v; b_in_data = d; b_in_ctrl = ctrl_of(d); b_in_sticky = s;
    b_out_ready = ordy; b_flush = fl;
    @(negedge clk);
    if (v && b_in_ready && !fl) qb.push_back({s, ctrl_of(d), d});
    @(posedge clk); #1;
  endtask

  // Monitor A: every taken beat must match the oldest expected beat
  always @(negedge clk) begin
    if (!reset) begin
      if (a_flush) begin
        qa.delete();
      end else if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) begin
          check("a_unexpected_beat", {16'h0, a_out_data}, 32'hFFFF_FFFF);
        end else begin
          logic [24:0] e;
          e = qa.pop_front();
          check("a_data", a_out_data, e[15:0]);
          check("a_ctrl", a_out_ctrl, e[23:16]);
          check("a_sticky", a_out_sticky, e[24]);
        end
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (!reset) begin
      if (b_flush) begin
        qb.delete();
      end else if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) begin
          check("b_unexpected_beat", {16'h0, b_out_data}, 32'hFFFF_FFFF);
        end else begin
          logic [24:0] e;
          e = qb.pop_front();
          check("b_data", b_out_data, e[15:0]);
          check("b_ctrl", b_out_ctrl, e[23:16]);
          check("b_sticky", b_out_sticky, e[24]);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check("a_rst_valid", a_out_valid, 0);
    check("a_rst_occ", a_occ, 0);
    check("a_rst_ready", a_in_ready, 1);
    check("a_rst_ctrl", a_out_ctrl, 0);
    check("a_rst_data", a_out_data, 0);
    check("a_rst_sticky", a_out_sticky, 0);
    check("b_rst_ready", b_in_ready, 1);
    check("b_rst_occ", b_occ, 0);

    // A: streaming 1..8 with out_ready high, no bubbles
    for (int i = 1; i <= 8; i++) begin
      drive_a(1'b1, 16'(i), 1'b0, 1'b1, 1'b0);
      check("a_stream_valid", a_out_valid, 1);
      check("a_stream_occ", a_occ, 1);
      check("a_stream_data", a_out_data, i);
    end
    drive_a(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("a_drain_occ", a_occ, 0);

    // A: skid fill with out_ready low, then drain in order
    drive_a(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0);
    check("a_skid1_occ", a_occ, 1);
    check("a_skid1_ready", a_in_ready, 1);
    drive_a(1'b1, 16'h000B, 1'b0, 1'b0, 1'b0);
    check("a_full_occ", a_occ, 2);
    check("a_full_ready", a_in_ready, 0);
    check("a_full_data", a_out_data, 16'h000A);
    drive_a(1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
    check("a_hold_occ", a_occ, 2);
    drive_a(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("a_drain1_occ", a_occ, 1);
    check("a_drain1_ready", a_in_ready, 1);
    check("a_drain1_data", a_out_data, 16'h000B);
    drive_a(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("a_drain2_occ", a_occ, 0);

    // A: flush at occupancy 2 with sticky held
    drive_a(1'b1, 16'h0011, 1'b1, 1'b0, 1'b0);
    drive_a(1'b1, 16'h0022, 1'b1, 1'b0, 1'b0);
    check("a_pre_flush_occ", a_occ, 2);
    check("a_pre_flush_sticky", a_out_sticky, 1);
    drive_a(1'b1, 16'h0033, 1'b0, 1'b0, 1'b1);
    check("a_flush_valid", a_out_valid, 0);
    check("a_flush_ctrl", a_out_ctrl, 0);
    check("a_flush_data", a_out_data, 0);
    check("a_flush_sticky", a_out_sticky, 1);
    check("a_flush_occ", a_occ, 0);
    check("a_flush_ready", a_in_ready, 1);
    for (int i = 0; i < 2; i++) begin
      drive_a(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      check("a_post_flush_valid", a_out_valid, 0);
    end

    // A: asynchronous reset mid-stream at occupancy 2
    drive_a(1'b1, 16'h0044, 1'b1, 1'b0, 1'b0);
    drive_a(1'b1, 16'h0055, 1'b1, 1'b0, 1'b0);
    check("a_pre_rst_occ", a_occ, 2);
    a_in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("a_midrst_valid", a_out_valid, 0);
    check("a_midrst_occ", a_occ, 0);
    check("a_midrst_sticky", a_out_sticky, 0);
    qa.delete();
    qb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("a_post_rst_ready", a_in_ready, 1);
    check("a_post_rst_valid", a_out_valid, 0);

    // B: combinational ready with no skid
    drive_b(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    check("b_load_valid", b_out_valid, 1);
    check("b_load_data", b_out_data, 16'hBEEF);
    b_in_valid = 1'b1; b_in_data = 16'hDEAD; b_in_ctrl = ctrl_of(16'hDEAD);
    b_in_sticky = 1'b0; b_out_ready = 1'b0;
    #1 check("b_stall_ready", b_in_ready, 0);
    b_out_ready = 1'b1;
    #1 check("b_comb_ready", b_in_ready, 1);
    @(negedge clk);
    if (b_in_ready) qb.push_back({1'b0, ctrl_of(16'hDEAD), 16'hDEAD});
    @(posedge clk); #1;
    check("b_replace_data", b_out_data, 16'hDEAD);
    check("b_replace_occ", b_occ, 1);

    // B: flush with data retained, same-cycle beat discarded although ready
    drive_b(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1);
    check("b_flush_valid", b_out_valid, 0);
    check("b_flush_ctrl", b_out_ctrl, 0);
    check("b_flush_data", b_out_data, 16'hDEAD);
    check("b_flush_occ", b_occ, 0);
    check("b_flush_ready", b_in_ready, 1);
    for (int i = 0; i < 2; i++) begin
      drive_b(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      check("b_post_flush_valid", b_out_valid, 0);
    end

    // B: short stream with sticky on the second beat
    drive_b(1'b1, 16'h0101, 1'b0, 1'b1, 1'b0);
    drive_b(1'b1, 16'h0202, 1'b1, 1'b1, 1'b0);
    check("b_stream_sticky", b_out_sticky, 1);
    check("b_stream_occ", b_occ, 1);
    drive_b(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    check("b_stream_end_occ", b_occ, 0);

    repeat (2) @(posedge clk);
    #1;
    check("a_queue_empty", qa.size(), 0);
    check("b_queue_empty", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
